// File: rtl/iiitb_gpio_port.sv
// iiitb_gpio_port: register-mapped GPIO port between the iiitb_rv32i core and the pads.
//
// Parameters:
//   WIDTH      number of pins (1..32)
//   OEB_RESET  reset value of the output-enable-bar register (1 = input)
//   PULSE_LEN  pulse duration in clk cycles (>= 1)
// Ports:
//   clk, RN            clock and asynchronous active-low reset
//   wr_en/wr_addr/wr_data  register write (one per cycle)
//   rd_addr/rd_data    combinational register read
//   pad_in             asynchronous pad inputs
//   pad_out, pad_oeb   registered pad drive value and output-enable-bar
//   edge_irq           registered level interrupt from enabled edge flags
module iiitb_gpio_port #(
    parameter int unsigned       WIDTH     = 16,
    parameter logic [WIDTH-1:0]  OEB_RESET = '1,
    parameter int unsigned       PULSE_LEN = 8
) (
    input  logic             clk,
    input  logic             RN,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [2:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] pad_out,
    output logic [WIDTH-1:0] pad_oeb,
    output logic             edge_irq
);

    localparam int unsigned CntW = $clog2(PULSE_LEN + 1);

    localparam logic [2:0] AddrData   = 3'd0;
    localparam logic [2:0] AddrOeb    = 3'd1;
    localparam logic [2:0] AddrSet    = 3'd2;
    localparam logic [2:0] AddrClr    = 3'd3;
    localparam logic [2:0] AddrTgl    = 3'd4;
    localparam logic [2:0] AddrPulse  = 3'd5;
    localparam logic [2:0] AddrEdgClr = 3'd6;
    localparam logic [2:0] AddrIrqEn  = 3'd7;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] oeb_q, oeb_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] flags_q, flags_d;
    logic [WIDTH-1:0] irq_en_q, irq_en_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] sync1_q, in_sync_q, in_prev_q;
    logic [1:0]       warm_q, warm_d;
    logic [WIDTH-1:0] edge_clr, rise;

    always_comb begin
        out_d    = out_q;
        mask_d   = mask_q;
        cnt_d    = cnt_q;
        oeb_d    = oeb_q;
        irq_en_d = irq_en_q;
        edge_clr = '0;

        // Expiry is applied first so that a same-cycle write overrides it.
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
        if (cnt_q == CntW'(1)) begin
            out_d  = out_q & ~mask_q;
            mask_d = '0;
        end

        if (wr_en) begin
            unique case (wr_addr)
                AddrData:   out_d    = wr_data;
                AddrOeb:    oeb_d    = wr_data;
                AddrSet:    out_d    = out_d | wr_data;
                AddrClr:    out_d    = out_d & ~wr_data;
                AddrTgl:    out_d    = out_d ^ wr_data;
                AddrPulse: begin
                    out_d  = out_d | wr_data;
                    mask_d = mask_d | wr_data;
                    cnt_d  = CntW'(PULSE_LEN);
                end
                AddrEdgClr: edge_clr = wr_data;
                AddrIrqEn:  irq_en_d = wr_data;
            endcase
        end

        // Warm-up hides the synchroniser filling with pads already high at reset.
        rise    = in_sync_q & ~in_prev_q & {WIDTH{warm_q == 2'd3}};
        flags_d = (flags_q & ~edge_clr) | rise;
        irq_d   = |(flags_q & irq_en_q);
        warm_d  = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
    end

    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            out_q     <= '0;
            oeb_q     <= OEB_RESET;
            mask_q    <= '0;
            cnt_q     <= '0;
            flags_q   <= '0;
            irq_en_q  <= '0;
            irq_q     <= 1'b0;
            sync1_q   <= '0;
            in_sync_q <= '0;
            in_prev_q <= '0;
            warm_q    <= 2'd0;
        end else begin
            out_q     <= out_d;
            oeb_q     <= oeb_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            flags_q   <= flags_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
            sync1_q   <= pad_in;
            in_sync_q <= sync1_q;
            in_prev_q <= in_sync_q;
            warm_q    <= warm_d;
        end
    end

    always_comb begin
        rd_data = '0;
        unique case (rd_addr)
            3'd0:    rd_data = out_q;
            3'd1:    rd_data = oeb_q;
            3'd2:    rd_data = in_sync_q;
            3'd3:    rd_data = flags_q;
            3'd4:    rd_data = mask_q;
            3'd7:    rd_data = irq_en_q;
            default: rd_data = '0;
        endcase
    end

    assign pad_out  = out_q;
    assign pad_oeb  = oeb_q;
    assign edge_irq = irq_q;

endmodule

// File: tb/tb_iiitb_gpio_port.sv
// Self-checking bench for iiitb_gpio_port (WIDTH=16, PULSE_LEN=8): directed scenarios
// plus randomized traffic compared against a behavioural model.
module tb_iiitb_gpio_port;

    localparam int W  = 16;
    localparam int PL = 8;

    logic          clk = 1'b0;
    logic          RN = 1'b0;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic [2:0]    rd_addr = '0;
    logic [W-1:0]  rd_data;
    logic [W-1:0]  pad_in = '1;
    logic [W-1:0]  pad_out;
    logic [W-1:0]  pad_oeb;
    logic          edge_irq;

    int checks = 0;
    int errors = 0;

    iiitb_gpio_port #(
        .WIDTH    (W),
        .OEB_RESET({W{1'b1}}),
        .PULSE_LEN(PL)
    ) dut (
        .clk     (clk),
        .RN      (RN),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .pad_in  (pad_in),
        .pad_out (pad_out),
        .pad_oeb (pad_oeb),
        .edge_irq(edge_irq)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Edges are numbered from 1 after reset release; padq[k-1] is pad_in sampled at edge k.
    logic [W-1:0] m_out, m_oeb, m_mask, m_flags, m_en;
    logic         m_irq;
    int           m_e;
    int           m_exp;
    bit           m_act;
    logic [W-1:0] padq[$];

    function automatic logic [W-1:0] pad_at(int k);
        if (k < 1 || k > padq.size()) return '0;
        return padq[k-1];
    endfunction

    task automatic model_reset();
        m_out = '0; m_oeb = '1; m_mask = '0; m_flags = '0; m_en = '0;
        m_irq = 1'b0; m_e = 0; m_exp = 0; m_act = 1'b0;
        padq.delete();
    endtask

    task automatic model_edge();
        int e;
        logic [W-1:0] rise, clr;
        logic new_irq;
        e = m_e + 1;
        // A pad level reaches in_sync two edges after sampling; its rise is flagged one
        // edge later, and nothing may be flagged during the first three edges.
        rise = (e >= 4) ? (pad_at(e - 2) & ~pad_at(e - 3)) : '0;
        padq.push_back(pad_in);
        m_e = e;
        new_irq = |(m_flags & m_en);
        clr = (wr_en && wr_addr == 3'd6) ? wr_data : '0;
        m_flags = (m_flags & ~clr) | rise;
        m_irq = new_irq;
        if (m_act && e == m_exp) begin
            m_out  = m_out & ~m_mask;
            m_mask = '0;
            m_act  = 1'b0;
        end
        if (wr_en) begin
            case (wr_addr)
                3'd0: m_out = wr_data;
                3'd1: m_oeb = wr_data;
                3'd2: m_out = m_out | wr_data;
                3'd3: m_out = m_out & ~wr_data;
                3'd4: m_out = m_out ^ wr_data;
                3'd5: begin
                    m_out  = m_out | wr_data;
                    m_mask = m_mask | wr_data;
                    m_exp  = e + PL;
                    m_act  = 1'b1;
                end
                3'd7: m_en = wr_data;
                default: ;
            endcase
        end
    endtask

    function automatic logic [W-1:0] model_rd(logic [2:0] a);
        case (a)
            3'd0: return m_out;
            3'd1: return m_oeb;
            3'd2: return pad_at(m_e - 1);
            3'd3: return m_flags;
            3'd4: return m_mask;
            3'd7: return m_en;
            default: return '0;
        endcase
    endfunction

    // Advance one clock; leaves time 1 unit after the rising edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0; wr_data = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_write(3'd0, 16'h1234);
        do_write(3'd5, 16'h0100);
        step();
        RN = 1'b0;
        #1;
        checks++;
        if (pad_out !== 16'h0000) begin
            errors++; $display("FAIL reset_pad_out: got %h expected 0000", pad_out);
        end
        checks++;
        if (pad_oeb !== 16'hFFFF) begin
            errors++; $display("FAIL reset_pad_oeb: got %h expected ffff", pad_oeb);
        end
        checks++;
        if (edge_irq !== 1'b0) begin
            errors++; $display("FAIL reset_irq: got %b expected 0", edge_irq);
        end
        model_reset();
        #1;
        RN = 1'b1;
        for (int i = 0; i < 6; i++) step();
        rd_addr = 3'd3;
        #1;
        checks++;
        if (rd_data !== 16'h0000) begin
            errors++; $display("FAIL warmup_flags: got %h expected 0000", rd_data);
        end
        rd_addr = 3'd2;
        #1;
        checks++;
        if (rd_data !== 16'hFFFF) begin
            errors++; $display("FAIL reset_in_sync: got %h expected ffff", rd_data);
        end
    endtask

    task automatic test_atomic();
        logic [2:0]   addrs[4] = '{3'd0, 3'd2, 3'd3, 3'd4};
        logic [W-1:0] datas[4] = '{16'h00F0, 16'h0F00, 16'h0030, 16'h8001};
        logic [W-1:0] exps[4]  = '{16'h00F0, 16'h0FF0, 16'h0FC0, 16'h8FC1};
        pad_in = '0;
        for (int i = 0; i < 4; i++) begin
            do_write(addrs[i], datas[i]);
            checks++;
            if (pad_out !== exps[i]) begin
                errors++; $display("FAIL atomic_%0d: got %h expected %h", i, pad_out, exps[i]);
            end
        end
    endtask

    task automatic test_pulse();
        do_write(3'd0, '0);
        // Single pulse: high for exactly PL cycles.
        do_write(3'd5, 16'h0004);
        checks++;
        if (pad_out !== 16'h0004) begin
            errors++; $display("FAIL pulse_start: got %h expected 0004", pad_out);
        end
        for (int i = 1; i < PL; i++) begin
            step();
            checks++;
            if (pad_out !== 16'h0004) begin
                errors++; $display("FAIL pulse_hold_%0d: got %h expected 0004", i, pad_out);
            end
        end
        step();
        checks++;
        if (pad_out !== 16'h0000) begin
            errors++; $display("FAIL pulse_expire: got %h expected 0000", pad_out);
        end
        // Overlapping pulse extends the earlier pin.
        do_write(3'd5, 16'h0004);
        for (int i = 1; i < 5; i++) step();
        do_write(3'd5, 16'h0008);
        for (int i = 6; i <= 12; i++) step();
        checks++;
        if (pad_out !== 16'h000C) begin
            errors++; $display("FAIL pulse_merge_hold: got %h expected 000c", pad_out);
        end
        step();
        checks++;
        if (pad_out !== 16'h0000) begin
            errors++; $display("FAIL pulse_merge_expire: got %h expected 0000", pad_out);
        end
        // SET on the expiry cycle wins.
        do_write(3'd5, 16'h0004);
        for (int i = 1; i < PL; i++) step();
        do_write(3'd2, 16'h0004);
        checks++;
        if (pad_out !== 16'h0004) begin
            errors++; $display("FAIL pulse_set_on_expiry: got %h expected 0004", pad_out);
        end
        rd_addr = 3'd4;
        #1;
        checks++;
        if (rd_data !== 16'h0000) begin
            errors++; $display("FAIL pulse_mask_cleared: got %h expected 0000", rd_data);
        end
        do_write(3'd3, 16'h0004);
    endtask

    task automatic test_edge_irq();
        pad_in = '0;
        for (int i = 0; i < 4; i++) step();
        do_write(3'd6, '1);
        do_write(3'd7, 16'h0001);
        pad_in[0] = 1'b1;
        step();
        step();
        rd_addr = 3'd3;
        #1;
        checks++;
        if (rd_data !== 16'h0000) begin
            errors++; $display("FAIL edge_flag_early: got %h expected 0000", rd_data);
        end
        step();
        checks++;
        if (rd_data !== 16'h0001) begin
            errors++; $display("FAIL edge_flag_set: got %h expected 0001", rd_data);
        end
        checks++;
        if (edge_irq !== 1'b0) begin
            errors++; $display("FAIL irq_early: got %b expected 0", edge_irq);
        end
        step();
        checks++;
        if (edge_irq !== 1'b1) begin
            errors++; $display("FAIL irq_rise: got %b expected 1", edge_irq);
        end
        do_write(3'd6, 16'h0001);
        checks++;
        if (rd_data !== 16'h0000) begin
            errors++; $display("FAIL edge_clr: got %h expected 0000", rd_data);
        end
        step();
        checks++;
        if (edge_irq !== 1'b0) begin
            errors++; $display("FAIL irq_fall: got %b expected 0", edge_irq);
        end
        // Clear coinciding with a new edge: set wins.
        pad_in[0] = 1'b0;
        for (int i = 0; i < 4; i++) step();
        pad_in[0] = 1'b1;
        step();
        step();
        do_write(3'd6, 16'h0001);
        checks++;
        if (rd_data !== 16'h0001) begin
            errors++; $display("FAIL edge_set_beats_clr: got %h expected 0001", rd_data);
        end
        do_write(3'd6, '1);
        do_write(3'd7, '0);
    endtask

    task automatic test_oeb();
        do_write(3'd1, 16'h0000);
        checks++;
        if (pad_oeb !== 16'h0000) begin
            errors++; $display("FAIL oeb_write: got %h expected 0000", pad_oeb);
        end
        do_write(3'd1, 16'h0010);
        do_write(3'd0, 16'h0000);
        do_write(3'd5, 16'h0010);
        checks++;
        if (pad_out !== 16'h0010 || pad_oeb !== 16'h0010) begin
            errors++;
            $display("FAIL oeb_pulse: got out=%h oeb=%h expected out=0010 oeb=0010",
                     pad_out, pad_oeb);
        end
        for (int i = 0; i < PL; i++) step();
        checks++;
        if (pad_out !== 16'h0000 || pad_oeb !== 16'h0010) begin
            errors++;
            $display("FAIL oeb_pulse_end: got out=%h oeb=%h expected out=0000 oeb=0010",
                     pad_out, pad_oeb);
        end
        rd_addr = 3'd5;
        #1;
        checks++;
        if (rd_data !== 16'h0000) begin
            errors++; $display("FAIL rd_addr5: got %h expected 0000", rd_data);
        end
        rd_addr = 3'd6;
        #1;
        checks++;
        if (rd_data !== 16'h0000) begin
            errors++; $display("FAIL rd_addr6: got %h expected 0000", rd_data);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_rd;
        for (int i = 0; i < 400; i++) begin
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = W'($urandom);
            if (wr_addr == 3'd5 || wr_addr == 3'd6) wr_data = wr_data & W'($urandom);
            if ($urandom_range(0, 3) == 0) pad_in = pad_in ^ W'($urandom);
            rd_addr = 3'($urandom_range(0, 7));
            step();
            exp_rd = model_rd(rd_addr);
            checks++;
            if (pad_out !== m_out || pad_oeb !== m_oeb || edge_irq !== m_irq ||
                rd_data !== exp_rd) begin
                errors++;
                $display("FAIL random_%0d: got out=%h oeb=%h irq=%b rd[%0d]=%h expected out=%h oeb=%h irq=%b rd=%h",
                         i, pad_out, pad_oeb, edge_irq, rd_addr, rd_data,
                         m_out, m_oeb, m_irq, exp_rd);
            end
        end
        wr_en = 1'b0;
    endtask

    initial begin
        model_reset();
        #7;
        RN = 1'b1;
        test_reset();
        test_atomic();
        test_pulse();
        test_edge_irq();
        test_oeb();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
